// File: rtl/m6502_bus_pkg.sv
// Shared types and address decode for the m6502 bus responder.
// Vector page sits at the very top of the 64 KiB space.
package m6502_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_VEC,
    RGN_NONE
  } region_e;

  localparam logic [15:0] VECTOR_BASE = 16'hFFFA;

  function automatic region_e decode(
    input logic [15:0] a,
    input int unsigned aw
  );
    logic [16:0] lim;
    lim = 17'd1 << aw;
    if ({1'b0, a} < lim)
      return RGN_RAM;
    else if (a >= VECTOR_BASE)
      return RGN_VEC;
    else
      return RGN_NONE;
  endfunction

endpackage

// File: rtl/m6502_bus_ram.sv
// Byte RAM: one write port, one enabled synchronous read port.
// Read-before-write, so a same-cycle write leaves the read at the old byte.
module m6502_bus_ram #(
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/m6502_bus_responder.sv
// Memory-side responder for the m6502 CPU bus: RAM window,
// fixed vector page, wait-state insertion and a side load port.
module m6502_bus_responder
  import m6502_bus_pkg::*;
#(
  parameter int unsigned RAM_ADDR_W   = 12,
  parameter int unsigned WAIT_STATES  = 0,
  parameter logic [15:0] NMI_VECTOR   = 16'h0000,
  parameter logic [15:0] RESET_VECTOR = 16'h0200,
  parameter logic [15:0] IRQ_VECTOR   = 16'h0000,
  parameter logic [7:0]  OPEN_BUS     = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [15:0]           addr,
  input  logic                  rd_req,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic [7:0]            rd_data,
  output logic                  ready,
  input  logic                  ld_en,
  input  logic [RAM_ADDR_W-1:0] ld_addr,
  input  logic [7:0]            ld_data,
  output logic                  ld_drop,
  output logic                  bus_err
);

  if (WAIT_STATES > 15) begin : g_ws_check
    $error("WAIT_STATES must be in 0..15");
  end

  localparam logic [3:0] WS_M1 = 4'(WAIT_STATES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic        rd_pend_q, rd_pend_d;
  logic [7:0]  hold_q, hold_d;
  logic        src_ram_q, src_ram_d;
  logic        ready_q, ready_d;
  logic        bus_err_q, bus_err_d;
  logic        ld_drop_q, ld_drop_d;

  region_e     rgn;
  logic        idle, strobe, accept;
  logic        is_rd, is_wr;
  logic        cpu_we, ram_re;
  logic        ram_we;
  logic [RAM_ADDR_W-1:0] ram_waddr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  function automatic logic [7:0] fixed_byte(
    input logic [15:0] a
  );
    logic [7:0] b;
    b = OPEN_BUS;
    if (decode(a, RAM_ADDR_W) == RGN_VEC) begin
      case (a[2:0])
        3'b010:  b = NMI_VECTOR[7:0];
        3'b011:  b = NMI_VECTOR[15:8];
        3'b100:  b = RESET_VECTOR[7:0];
        3'b101:  b = RESET_VECTOR[15:8];
        3'b110:  b = IRQ_VECTOR[7:0];
        3'b111:  b = IRQ_VECTOR[15:8];
        default: b = OPEN_BUS;
      endcase
    end
    return b;
  endfunction

  always_comb begin
    rgn    = decode(addr, RAM_ADDR_W);
    idle   = (state_q == ST_IDLE);
    strobe = rd_req | wr_en;
    accept = strobe & idle;
    is_wr  = accept & wr_en;
    is_rd  = accept & rd_req & ~wr_en;
    cpu_we = is_wr & (rgn == RGN_RAM);
    ram_re = is_rd & (rgn == RGN_RAM);

    // CPU owns the single write port on a collision
    ram_we    = cpu_we | ld_en;
    ram_waddr = cpu_we ? addr[RAM_ADDR_W-1:0] : ld_addr;
    ram_wdata = cpu_we ? wr_data : ld_data;

    bus_err_d = strobe & (~idle
              | (rd_req & wr_en)
              | (is_rd & (rgn == RGN_NONE))
              | (is_wr & (rgn != RGN_RAM)));
    ld_drop_d = ld_en & cpu_we;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rd_pend_d = rd_pend_q;
    hold_d    = hold_q;
    src_ram_d = src_ram_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d    = addr;
          rd_pend_d = is_rd;
          if (WAIT_STATES == 0) begin
            if (is_rd) begin
              src_ram_d = (rgn == RGN_RAM);
              if (rgn != RGN_RAM)
                hold_d = fixed_byte(addr);
            end
          end else begin
            state_d = (WAIT_STATES == 1) ? ST_DONE : ST_WAIT;
            cnt_d   = WS_M1;
            // freeze the old RAM byte before the new read lands
            if (is_rd && src_ram_q) begin
              hold_d    = ram_rdata;
              src_ram_d = 1'b0;
            end
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd0)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        rd_pend_d = 1'b0;
        if (rd_pend_q) begin
          src_ram_d = (decode(addr_q, RAM_ADDR_W) == RGN_RAM);
          if (!src_ram_d)
            hold_d = fixed_byte(addr_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 16'h0000;
      rd_pend_q <= 1'b0;
      hold_q    <= 8'h00;
      src_ram_q <= 1'b0;
      ready_q   <= 1'b1;
      bus_err_q <= 1'b0;
      ld_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rd_pend_q <= rd_pend_d;
      hold_q    <= hold_d;
      src_ram_q <= src_ram_d;
      ready_q   <= ready_d;
      bus_err_q <= bus_err_d;
      ld_drop_q <= ld_drop_d;
    end
  end

  m6502_bus_ram #(
    .AW(RAM_ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (addr[RAM_ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  assign rd_data = src_ram_q ? ram_rdata : hold_q;
  assign ready   = ready_q;
  assign bus_err = bus_err_q;
  assign ld_drop = ld_drop_q;

endmodule

// File: tb/tb_m6502_bus_responder.sv
// Scoreboard bench for m6502_bus_responder at several wait-state
// settings; one DUT per setting, each with its own stimulus.
module tb_m6502_bus_responder;

  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n   [NI];
  logic        rd_req  [NI];
  logic        wr_en   [NI];
  logic        ld_en   [NI];
  logic        ready   [NI];
  logic        ld_drop [NI];
  logic        bus_err [NI];
  logic [15:0] addr    [NI];
  logic [7:0]  wr_data [NI];
  logic [7:0]  ld_data [NI];
  logic [7:0]  rd_data [NI];
  logic [11:0] ld_addr [NI];

  logic [7:0] mem_m [NI][4096];
  logic [7:0] sbq [$];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int ws_of(input int k);
    case (k)
      0:       return 0;
      1:       return 2;
      2:       return 3;
      default: return 5;
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    m6502_bus_responder #(
      .RAM_ADDR_W   (12),
      .WAIT_STATES  (g == 0 ? 0 : g == 1 ? 2 : g == 2 ? 3 : 5),
      .RESET_VECTOR (16'hC000)
    ) u_dut (
      .clk     (clk),
      .reset_n (rst_n[g]),
      .addr    (addr[g]),
      .rd_req  (rd_req[g]),
      .wr_en   (wr_en[g]),
      .wr_data (wr_data[g]),
      .rd_data (rd_data[g]),
      .ready   (ready[g]),
      .ld_en   (ld_en[g]),
      .ld_addr (ld_addr[g]),
      .ld_data (ld_data[g]),
      .ld_drop (ld_drop[g]),
      .bus_err (bus_err[g])
    );
  end

  task automatic check(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_rd(
    input int k,
    input logic [15:0] a
  );
    if (a < 16'h1000)
      return mem_m[k][a[11:0]];
    case (a)
      16'hFFFC: return 8'h00;
      16'hFFFD: return 8'hC0;
      16'hFFFA, 16'hFFFB,
      16'hFFFE, 16'hFFFF: return 8'h00;
      default:  return 8'hFF;
    endcase
  endfunction

  function automatic bit model_err(
    input bit r,
    input bit w,
    input logic [15:0] a
  );
    return (r && w)
        || (r && !w && a >= 16'h1000 && a < 16'hFFFA)
        || (w && a >= 16'h1000);
  endfunction

  task automatic access(
    input int          k,
    input bit          r,
    input bit          w,
    input logic [15:0] a,
    input logic [7:0]  d,
    input string       tag
  );
    bit e;
    e = model_err(r, w, a);
    @(negedge clk);
    rd_req[k]  = r;
    wr_en[k]   = w;
    addr[k]    = a;
    wr_data[k] = d;
    if (r && !w)
      sbq.push_back(model_rd(k, a));
    if (w && a < 16'h1000)
      mem_m[k][a[11:0]] = d;
    @(negedge clk);
    rd_req[k] = 1'b0;
    wr_en[k]  = 1'b0;
    check({tag, ".err"}, 16'(bus_err[k]), 16'(e));
    for (int i = 0; i < ws_of(k); i++) begin
      check({tag, ".busy"}, 16'(ready[k]), 16'h0);
      @(negedge clk);
    end
    check({tag, ".rdy"}, 16'(ready[k]), 16'h1);
    if (r && !w)
      check({tag, ".data"}, 16'(rd_data[k]), 16'(sbq.pop_front()));
  endtask

  task automatic load(
    input int          k,
    input logic [11:0] a,
    input logic [7:0]  d
  );
    @(negedge clk);
    ld_en[k]   = 1'b1;
    ld_addr[k] = a;
    ld_data[k] = d;
    mem_m[k][a] = d;
    @(negedge clk);
    ld_en[k] = 1'b0;
    check("ld.nodrop", 16'(ld_drop[k]), 16'h0);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst_n[k]   = 1'b0;
      rd_req[k]  = 1'b0;
      wr_en[k]   = 1'b0;
      ld_en[k]   = 1'b0;
      addr[k]    = 16'h0;
      wr_data[k] = 8'h0;
      ld_data[k] = 8'h0;
      ld_addr[k] = 12'h0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("rst.ready", 16'(ready[k]), 16'h1);
      check("rst.data", 16'(rd_data[k]), 16'h0);
      check("rst.err", 16'(bus_err[k]), 16'h0);
      check("rst.drop", 16'(ld_drop[k]), 16'h0);
    end

    // vector page with two wait states
    access(1, 1'b1, 1'b0, 16'hFFFC, 8'h00, "vec_lo");
    access(1, 1'b1, 1'b0, 16'hFFFD, 8'h00, "vec_hi");
    access(1, 1'b1, 1'b0, 16'hFFFA, 8'h00, "nmi_lo");
    access(1, 1'b0, 1'b1, 16'h1000, 8'h33, "w_unmap");

    // preload then back-to-back reads at zero wait states
    load(0, 12'h200, 8'hA9);
    load(0, 12'h201, 8'h42);
    @(negedge clk);
    rd_req[0] = 1'b1;
    addr[0]   = 16'h0200;
    sbq.push_back(model_rd(0, 16'h0200));
    @(negedge clk);
    addr[0] = 16'h0201;
    sbq.push_back(model_rd(0, 16'h0201));
    check("b2b.rdy0", 16'(ready[0]), 16'h1);
    check("b2b.d0", 16'(rd_data[0]), 16'(sbq.pop_front()));
    @(negedge clk);
    rd_req[0] = 1'b0;
    check("b2b.rdy1", 16'(ready[0]), 16'h1);
    check("b2b.d1", 16'(rd_data[0]), 16'(sbq.pop_front()));

    // CPU write and load port collide on the same byte
    @(negedge clk);
    wr_en[0]   = 1'b1;
    addr[0]    = 16'h0010;
    wr_data[0] = 8'h55;
    ld_en[0]   = 1'b1;
    ld_addr[0] = 12'h010;
    ld_data[0] = 8'hAA;
    mem_m[0][12'h010] = 8'h55;
    @(negedge clk);
    wr_en[0] = 1'b0;
    ld_en[0] = 1'b0;
    check("coll.drop", 16'(ld_drop[0]), 16'h1);
    check("coll.err", 16'(bus_err[0]), 16'h0);
    @(negedge clk);
    check("coll.drop_end", 16'(ld_drop[0]), 16'h0);
    access(0, 1'b1, 1'b0, 16'h0010, 8'h00, "coll_rd");

    // decode and protocol errors
    access(0, 1'b1, 1'b0, 16'h8000, 8'h00, "unmapped");
    access(0, 1'b0, 1'b1, 16'hFFFC, 8'h12, "vec_wr");
    access(0, 1'b1, 1'b0, 16'hFFFC, 8'h00, "vec_after");
    access(0, 1'b1, 1'b1, 16'h0020, 8'h5A, "rdwr");
    access(0, 1'b1, 1'b0, 16'h0020, 8'h00, "rdwr_rd");
    access(1, 1'b0, 1'b1, 16'h0030, 8'h9C, "ws_wr");
    access(1, 1'b1, 1'b0, 16'h0030, 8'h00, "ws_rd");

    // second strobe while busy at three wait states
    load(2, 12'h300, 8'h77);
    load(2, 12'h010, 8'h11);
    @(negedge clk);
    rd_req[2] = 1'b1;
    addr[2]   = 16'h0300;
    sbq.push_back(model_rd(2, 16'h0300));
    @(negedge clk);
    check("busy.r1", 16'(ready[2]), 16'h0);
    check("busy.e1", 16'(bus_err[2]), 16'h0);
    addr[2] = 16'h0010;
    @(negedge clk);
    rd_req[2] = 1'b0;
    check("busy.e2", 16'(bus_err[2]), 16'h1);
    check("busy.r2", 16'(ready[2]), 16'h0);
    @(negedge clk);
    check("busy.r3", 16'(ready[2]), 16'h0);
    check("busy.e3", 16'(bus_err[2]), 16'h0);
    @(negedge clk);
    check("busy.r4", 16'(ready[2]), 16'h1);
    check("busy.d4", 16'(rd_data[2]), 16'(sbq.pop_front()));
    @(negedge clk);
    check("busy.r5", 16'(ready[2]), 16'h1);

    // reset in the middle of a five-wait-state read
    load(3, 12'h400, 8'h3C);
    access(3, 1'b1, 1'b0, 16'h0400, 8'h00, "pre_rst");
    @(negedge clk);
    rd_req[3] = 1'b1;
    addr[3]   = 16'h0400;
    @(negedge clk);
    rd_req[3] = 1'b0;
    check("mid.busy", 16'(ready[3]), 16'h0);
    @(negedge clk);
    rst_n[3] = 1'b0;
    @(negedge clk);
    check("mid.rdy", 16'(ready[3]), 16'h1);
    check("mid.data", 16'(rd_data[3]), 16'h0);
    rst_n[3] = 1'b1;
    access(3, 1'b1, 1'b0, 16'h0400, 8'h00, "post_rst");

    check("sb.empty", 16'(sbq.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
